// File: rtl/codificador_prioridad_reg_pkg.sv
// Shared definitions for the registered priority encoder.
// Holds the selection-mode constants and the index-width helper.
// No ports; imported by the selector and the top.
package codificador_prioridad_reg_pkg;

  localparam int MODO_FIJO = 0;  // fixed priority, highest index wins
  localparam int MODO_RR   = 1;  // round-robin after the last served index

  // Width of an index able to address n request lines (n >= 2).
  function automatic int calc_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/codificador_prioridad_reg_selector_prioridad.sv
// Purely combinational pick of one set bit from a request vector.
// Ports: vec (requests), inicio (first index scanned), encontrado (any bit set),
//        idx (chosen index). INVERSO scans downward from N-1 and ignores inicio.
module selector_prioridad
  import codificador_prioridad_reg_pkg::*;
#(
  parameter int N = 8,
  parameter bit INVERSO = 1'b0,
  localparam int W = calc_w(N)
) (
  input  logic [N-1:0] vec,
  input  logic [W-1:0] inicio,
  output logic         encontrado,
  output logic [W-1:0] idx
);

  int pos;

  // Walk candidates from lowest to highest scan rank backwards so the
  // last hit written is the one with the best rank.
  always_comb begin
    encontrado = 1'b0;
    idx        = '0;
    pos        = 0;
    for (int k = N - 1; k >= 0; k--) begin
      if (INVERSO) begin
        pos = N - 1 - k;
      end else begin
        pos = (int'(inicio) + k) % N;
      end
      if (vec[pos]) begin
        encontrado = 1'b1;
        idx        = W'(pos);
      end
    end
  end

endmodule

// File: rtl/codificador_prioridad_reg.sv
// Registered priority encoder: sticky pending requests, one index presented
// at a time under a valid/accept handshake; fixed-priority or round-robin.
// Ports: clk, rst_n (async low), en (capture enable), e (request pulses),
//        acepta (consumer takes s), s (index), valido, num_pend (popcount).
module codificador_prioridad_reg
  import codificador_prioridad_reg_pkg::*;
#(
  parameter int N = 8,
  parameter int MODO = MODO_FIJO,
  localparam int W = calc_w(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [N-1:0] e,
  input  logic         acepta,
  output logic [W-1:0] s,
  output logic         valido,
  output logic [W:0]   num_pend
);

  logic [N-1:0] pend;
  logic [N-1:0] pend_next;
  logic [N-1:0] servido;
  logic [W-1:0] ultimo;
  logic [W-1:0] ult_eff;
  logic [W-1:0] inicio;
  logic [W-1:0] sel_idx;
  logic         sel_ok;
  logic         atiende;
  logic [W:0]   cuenta;

  assign atiende = valido && acepta;

  always_comb begin
    servido = '0;
    for (int i = 0; i < N; i++) begin
      servido[i] = atiende && (s == W'(i));
    end
  end

  // A new request on the bit being served re-arms it (set beats clear).
  assign pend_next = (pend & ~servido) | (en ? e : '0);

  // The next round-robin scan must start after the index accepted this
  // cycle, not after the previously stored one, or it would repeat.
  assign ult_eff = atiende ? s : ultimo;

  always_comb begin
    inicio = '0;
    if (MODO == MODO_RR) begin
      inicio = (ult_eff == W'(N - 1)) ? '0 : ult_eff + W'(1);
    end
  end

  selector_prioridad #(
    .N       (N),
    .INVERSO (MODO == MODO_FIJO)
  ) u_sel (
    .vec        (pend_next),
    .inicio     (inicio),
    .encontrado (sel_ok),
    .idx        (sel_idx)
  );

  always_comb begin
    cuenta = '0;
    for (int i = 0; i < N; i++) begin
      cuenta = cuenta + (W + 1)'(pend_next[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend     <= '0;
      s        <= '0;
      valido   <= 1'b0;
      num_pend <= '0;
      ultimo   <= W'(N - 1);
    end else begin
      pend     <= pend_next;
      num_pend <= cuenta;
      if (atiende) begin
        ultimo <= s;
      end
      // A presented index is frozen until the consumer takes it.
      if (!valido || acepta) begin
        valido <= sel_ok;
        s      <= sel_ok ? sel_idx : '0;
      end
    end
  end

endmodule
